// File: rtl/alu_step_sequencer.sv
// Six-step control sequencer for a single-bus ALU datapath (fetch, decode, operand, execute, store).
// Optional macro SEQ_MEM_WAIT_EN: hold T1 until mem_ready is seen high.
module alu_step_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int ALU_W    = 5
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                unary,
    input  logic [ALU_W-1:0]    alu_op,
    input  logic [IDX_W-1:0]    src_a,
    input  logic [IDX_W-1:0]    src_b,
    input  logic [IDX_W-1:0]    dst,
    input  logic                mem_ready,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zlow_out,
    output logic [ALU_W-1:0]    alu_control,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5} state_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic pc_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
    } strobe_t;

    state_e               state_q, state_d;
    logic                 unary_q, unary_d;
    logic [ALU_W-1:0]     alu_op_q, alu_op_d;
    logic [IDX_W-1:0]     src_a_q, src_a_d;
    logic [IDX_W-1:0]     src_b_q, src_b_d;
    logic [IDX_W-1:0]     dst_q, dst_d;

    strobe_t              strb_q, strb_d;
    logic [NUM_REGS-1:0]  reg_in_q, reg_in_d;
    logic [NUM_REGS-1:0]  reg_out_q, reg_out_d;
    logic [ALU_W-1:0]     alu_ctl_q, alu_ctl_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Out-of-range indices match no bit, so they decode to all zeros.
    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) sel[i] = 1'b1;
        end
        return sel;
    endfunction

`ifndef SEQ_MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    always_comb begin
        state_d  = state_q;
        unary_d  = unary_q;
        alu_op_d = alu_op_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        case (state_q)
            StIdle, StT5: begin
                if (start) begin
                    state_d  = StT0;
                    unary_d  = unary;
                    alu_op_d = alu_op;
                    src_a_d  = src_a;
                    src_b_d  = src_b;
                    dst_d    = dst;
                end else begin
                    state_d = StIdle;
                end
            end
            StT0: state_d = StT1;
`ifdef SEQ_MEM_WAIT_EN
            StT1: state_d = mem_ready ? StT2 : StT1;
`else
            StT1: state_d = StT2;
`endif
            StT2: state_d = StT3;
            StT3: state_d = StT4;
            StT4: state_d = StT5;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy matches the current state.
    always_comb begin
        strb_d    = '0;
        reg_in_d  = '0;
        reg_out_d = '0;
        alu_ctl_d = '0;
        busy_d    = (state_d != StIdle);
        done_d    = 1'b0;
        case (state_d)
            StT0: begin
                strb_d.pc_out = 1'b1;
                strb_d.mar_in = 1'b1;
                strb_d.inc_pc = 1'b1;
                strb_d.z_in   = 1'b1;
            end
            StT1: begin
                strb_d.zlow_out = 1'b1;
                strb_d.pc_in    = 1'b1;
                strb_d.read     = 1'b1;
                strb_d.mdr_in   = 1'b1;
            end
            StT2: begin
                strb_d.mdr_out = 1'b1;
                strb_d.ir_in   = 1'b1;
            end
            StT3: begin
                reg_out_d   = decode(src_a_d);
                strb_d.y_in = 1'b1;
            end
            StT4: begin
                alu_ctl_d   = alu_op_d;
                strb_d.z_in = 1'b1;
                if (!unary_d) reg_out_d = decode(src_b_d);
            end
            StT5: begin
                strb_d.zlow_out = 1'b1;
                reg_in_d        = decode(dst_d);
                done_d          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= StIdle;
            unary_q   <= 1'b0;
            alu_op_q  <= '0;
            src_a_q   <= '0;
            src_b_q   <= '0;
            dst_q     <= '0;
            strb_q    <= '0;
            reg_in_q  <= '0;
            reg_out_q <= '0;
            alu_ctl_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            unary_q   <= unary_d;
            alu_op_q  <= alu_op_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
            dst_q     <= dst_d;
            strb_q    <= strb_d;
            reg_in_q  <= reg_in_d;
            reg_out_q <= reg_out_d;
            alu_ctl_q <= alu_ctl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign reg_in      = reg_in_q;
    assign reg_out     = reg_out_q;
    assign pc_out      = strb_q.pc_out;
    assign mar_in      = strb_q.mar_in;
    assign inc_pc      = strb_q.inc_pc;
    assign pc_in       = strb_q.pc_in;
    assign read        = strb_q.read;
    assign mdr_in      = strb_q.mdr_in;
    assign mdr_out     = strb_q.mdr_out;
    assign ir_in       = strb_q.ir_in;
    assign y_in        = strb_q.y_in;
    assign z_in        = strb_q.z_in;
    assign zlow_out    = strb_q.zlow_out;
    assign alu_control = alu_ctl_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: doc/alu_step_sequencer.md
ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 16: number of general registers; width of the one-hot register select buses.
REQ-002 Parameter IDX_W, default 4: register index width; the integrator sets IDX_W >= clog2(NUM_REGS).
REQ-003 Parameter ALU_W, default 5: ALU control code width.
REQ-004 Clock and reset: clock is the single clock; clear is an asynchronous, active-low reset.
REQ-005 Port clock, input, 1: rising-edge clock.
REQ-006 Port clear, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: request to run one ALU instruction sequence.
REQ-008 Port unary, input, 1: 1 selects a one-source operation (NOT/NEG); 0 selects a two-source operation.
REQ-009 Port alu_op, input, ALU_W: ALU code for the operation step.
REQ-010 Ports src_a, src_b, dst, input, IDX_W each: source and destination register indices.
REQ-011 Port mem_ready, input, 1: memory read data valid.
REQ-012 Ports reg_in and reg_out, output, NUM_REGS each: one-hot register load and drive strobes.
REQ-013 Ports pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, output, 1 each: datapath strobes.
REQ-014 Port alu_control, output, ALU_W: ALU code.
REQ-015 Ports busy and done, output, 1 each: sequence active, and completion pulse.

Function
REQ-016 States: IDLE, T0, T1, T2, T3, T4, T5; encoded state register; all outputs are Moore decodes of the state and the latched operands.
REQ-017 In IDLE, start=1 latches unary, alu_op, src_a, src_b and dst, and moves to T0 on the same edge; start is ignored in T0..T4.
REQ-018 T0 asserts pc_out, mar_in, inc_pc and z_in, with alu_control=0.
REQ-019 T1 asserts zlow_out, pc_in, read and mdr_in.
REQ-020 T2 asserts mdr_out and ir_in.
REQ-021 T3 asserts reg_out[src_a] and y_in.
REQ-022 T4 drives alu_control=latched alu_op and asserts z_in; it also asserts reg_out[src_b] only when unary=0.
REQ-023 T5 asserts zlow_out, reg_in[dst] and done.
REQ-024 busy=1 in T0..T5 and busy=0 in IDLE; every strobe not listed for a state is 0.
REQ-025 In T5, start=1 latches new operands and moves to T0 (back-to-back with no idle cycle); otherwise the next state is IDLE.
REQ-026 An index >= NUM_REGS asserts no bit of reg_in or reg_out, and the sequence proceeds unchanged.
REQ-027 At most one bit of reg_in and at most one bit of reg_out is 1 in any cycle.

Reset
REQ-028 clear=0 forces IDLE immediately, from any state including mid-sequence.
REQ-029 While clear=0, all outputs are 0 and all operand latches are 0.
REQ-030 The first start is accepted at the first rising edge after clear is released.

Configuration
REQ-031 Macro SEQ_MEM_WAIT_EN, when defined: T1 holds, with its strobes asserted, until the edge at which mem_ready=1, then moves to T2.
REQ-032 Without SEQ_MEM_WAIT_EN: T1 lasts exactly one cycle, mem_ready is ignored, and start-to-done latency is fixed at 6 cycles.

Verification
REQ-033 Unary NOT: start with unary=1, alu_op=5'b00101, src_a=7, dst=4 -> T3 reg_out=16'h0080 with y_in; T4 alu_control=5'b00101 with reg_out=0; T5 reg_in=16'h0010 with done; then IDLE.
REQ-034 Binary: unary=0, alu_op=5'b00011, src_a=2, src_b=3, dst=1 -> T3 reg_out=16'h0004; T4 reg_out=16'h0008; T5 reg_in=16'h0002.
REQ-035 Wait, with SEQ_MEM_WAIT_EN defined: mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles and done arrives 9 cycles after start; without the macro, done arrives 6 cycles after start.
REQ-036 Reset mid-sequence: clear=0 during T3 -> all outputs 0 and busy=0 immediately; a new start after release runs a full sequence from T0.
REQ-037 Back-to-back: start held high through T5 with a new dst=9 -> the next cycle is T0; the second T5 asserts reg_in=16'h0200; done pulses once per sequence.
REQ-038 Out-of-range index: NUM_REGS=12, dst=13 -> T5 reg_in=0, done=1; a one-hot check on reg_in and reg_out passes in every cycle of every test.
